execute_unit_p: RTL and testbench
=================================

Name: execute_unit_p

Overview:
- Parametrised next-generation execute stage of the ARM-like core. Sits between decode and fetch.
- Contains the register file, NZCV flags and word-addressed data memory.
- Adds a valid/ready handshake, a multi-cycle LDR with stall, conditional branches with a flush window, and configurable width and depth.

Parameters:
- DATA_W, 32, datapath and register width.
- NREGS, 16, number of registers. Power of two. SEL_W = log2(NREGS).
- MEM_WORDS, 64, data memory depth in words. Power of two.
- FLUSH_CYCLES, 2, cycles global_disable stays high after a taken branch. Must be 1 or more.
- FLAGS_ON_ALU, 0, controls which uops update NZCV. 0: only CMP. 1: ADD and SUB also update NZCV.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode presents a uop
- in_ready  out  1  uop accepted on the edge where in_valid && in_ready
- num_to_rhs  in  1  1: RHS = num; 0: RHS = reg[sel_p1]
- num  in  DATA_W  immediate, or signed branch offset
- sel_p0  in  SEL_W  first operand register (STR data)
- sel_p1  in  SEL_W  second operand register; address base for STR/LDR
- sel_in  in  SEL_W  destination register
- uop  in  5  operation code
- branch_cond  in  4  condition code for B
- global_disable  out  1  flush request to fetch/decode
- delta_instruction  out  DATA_W  signed PC delta; valid while branch_taken is high
- branch_taken  out  1  one-cycle pulse
- flags  out  4  {N,Z,C,V}

Behaviour:
- Reset values:
  - in_ready=1, global_disable=0, delta_instruction=0, branch_taken=0, flags=0.
  - All registers are 0.
  - Data memory is not reset.
- Operand selection:
  - LHS = reg[sel_p0], except STR/LDR, where the address is reg[sel_p1] + (num_to_rhs ? num : 0).
  - RHS is num when num_to_rhs=1, otherwise reg[sel_p1]. ALU ops use RHS as written.
- Register reads are combinational from the registered file. A write commits at the accepting edge, so a dependent uop in the following cycle sees the new value. No forwarding is needed.
- uop encoding:
  - 0 NOP
  - 1 ADD: reg[sel_in]=LHS+RHS
  - 2 SUB: reg[sel_in]=LHS-RHS
  - 3 AND
  - 4 ORR
  - 5 CMP: computes LHS-RHS, updates flags only
  - 6 EOR
  - 7 MVN: reg[sel_in]=~RHS
  - 8 MOV: reg[sel_in]=RHS when num_to_rhs=1, otherwise reg[sel_p0]
  - 9 STR: mem[addr]=reg[sel_p0]
  - 10 LDR: reg[sel_in]=mem[addr]
  - 11 B
  - 12-31: treated as NOP
- Arithmetic is modulo 2^DATA_W.
- Flags:
  - N = result MSB; Z = (result==0).
  - C = carry out for ADD; for SUB/CMP, C = no borrow (LHS >= RHS, unsigned).
  - V = signed overflow.
- Memory addressing: addr = low log2(MEM_WORDS) bits of the word address. Out-of-range addresses wrap.
- STR takes one cycle.
- LDR FSM, states IDLE and LOAD:
  - IDLE: on accept, register the address, go to LOAD, drive in_ready=0.
  - LOAD: the synchronous memory read data is written to reg[sel_in] (latched at accept). Return to IDLE, in_ready=1.
  - Total occupancy is 2 cycles.
- B:
  - Condition codes: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, 10 GE, 11 LT, 12 GT, 13 LE, 14 AL, 15 NV (never taken).
  - Taken branch, on the next cycle: branch_taken=1 for one cycle, delta_instruction=num, and the flush counter loads FLUSH_CYCLES.
  - Not taken: no output change; delta_instruction remains 0.
- Flush window:
  - global_disable=1 while the counter is nonzero.
  - Uops arriving in the window are accepted (in_ready=1) and squashed: no register, flag, memory or branch effects.
  - A squashed B never restarts the counter.
- Outside a taken-branch cycle, delta_instruction is 0.
- Reset mid-operation:
  - rst during LOAD abandons the load; no register write occurs.
  - rst during the flush window clears it immediately.
  - rst has priority over every other event.

Decomposition:
- Shared package exec_pkg holds:
  - uop constants (UOP_NOP … UOP_B)
  - condition-code constants (COND_EQ … COND_NV)
  - flag bit indices
- Natural sub-module: exec_alu_p (combinational; DATA_W parameter; computes result and NZCV). It is instantiated once.
- The condition evaluator is a function in exec_pkg.

Test Plan:
- MOV #0xCAFE→r1, MOV #0xDEAD→r2, ADD r1,r2→r4 → r4=0x0001A9AB; flags unchanged (0) with FLAGS_ON_ALU=0.
- MOV #1→r6, MOV #1→r7, CMP r6,r7 → flags=4'b0110 (Z=1, C=1). Then CMP r6,#2 → N=1, C=0, Z=0.
- STR r1 to r6+#28, then LDR r6+#28→r8, then ADD r8,r8→r9 back-to-back:
  - in_ready low exactly 1 cycle during LDR.
  - r8=0xCAFE, r9=0x195FC.
- After the Z=1 CMP, B EQ num=-3:
  - Next cycle branch_taken=1 and delta_instruction=0xFFFFFFFD.
  - global_disable high 2 cycles; a MOV #5→r10 issued in the window leaves r10=0.
- B with branch_cond=15 (NV) and B NE with Z=1 → no branch_taken, global_disable stays 0. B AL → taken.
- Assert rst in the LOAD cycle of LDR→r11 → r11=0, in_ready=1 after reset, flags=0. Also use DATA_W=16, MEM_WORDS=16: STR to address 20 readable at address 4 (wrap).

Source files
------------

// File: rtl/execute_unit_p_pkg.sv
// Shared uop/condition encodings, flag bit positions and the branch condition evaluator.
package exec_pkg;

   localparam logic [4:0] UOP_NOP = 5'd0;
   localparam logic [4:0] UOP_ADD = 5'd1;
   localparam logic [4:0] UOP_SUB = 5'd2;
   localparam logic [4:0] UOP_AND = 5'd3;
   localparam logic [4:0] UOP_ORR = 5'd4;
   localparam logic [4:0] UOP_CMP = 5'd5;
   localparam logic [4:0] UOP_EOR = 5'd6;
   localparam logic [4:0] UOP_MVN = 5'd7;
   localparam logic [4:0] UOP_MOV = 5'd8;
   localparam logic [4:0] UOP_STR = 5'd9;
   localparam logic [4:0] UOP_LDR = 5'd10;
   localparam logic [4:0] UOP_B   = 5'd11;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {ST_IDLE, ST_LOAD} ld_state_t;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      n = nzcv[FLAG_N];
      z = nzcv[FLAG_Z];
      c = nzcv[FLAG_C];
      v = nzcv[FLAG_V];
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return c;
         COND_CC: return !c;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return c && !z;
         COND_LS: return !c || z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z && (n == v);
         COND_LE: return z || (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/execute_unit_p_if.sv
// Decode-to-execute uop bus plus the branch/flush/flag results returned towards fetch.
interface execute_unit_p_if #(parameter int DATA_W = 32, parameter int SEL_W = 4);
   logic              in_valid;
   logic              in_ready;
   logic              num_to_rhs;
   logic [DATA_W-1:0] num;
   logic [SEL_W-1:0]  sel_p0;
   logic [SEL_W-1:0]  sel_p1;
   logic [SEL_W-1:0]  sel_in;
   logic [4:0]        uop;
   logic [3:0]        branch_cond;
   logic              global_disable;
   logic [DATA_W-1:0] delta_instruction;
   logic              branch_taken;
   logic [3:0]        flags;

   modport master (
      output in_valid, num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond,
      input  in_ready, global_disable, delta_instruction, branch_taken, flags
   );

   modport slave (
      input  in_valid, num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond,
      output in_ready, global_disable, delta_instruction, branch_taken, flags
   );
endinterface

// File: rtl/execute_unit_p_alu.sv
// Combinational ALU: result and NZCV for one uop; C on subtract means "no borrow".
module exec_alu_p
   import exec_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [4:0]        i_uop,
   input  logic [DATA_W-1:0] i_lhs,
   input  logic [DATA_W-1:0] i_rhs,
   output logic [DATA_W-1:0] o_result,
   output logic [3:0]        o_nzcv
);
   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;
   logic            w_c;
   logic            w_v;

   assign w_sum  = {1'b0, i_lhs} + {1'b0, i_rhs};
   assign w_diff = {1'b0, i_lhs} - {1'b0, i_rhs};

   always_comb begin
      o_result = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (i_uop)
         UOP_ADD: begin
            o_result = w_sum[DATA_W-1:0];
            w_c      = w_sum[DATA_W];
            w_v      = (i_lhs[DATA_W-1] == i_rhs[DATA_W-1]) && (w_sum[DATA_W-1] != i_lhs[DATA_W-1]);
         end
         UOP_SUB, UOP_CMP: begin
            o_result = w_diff[DATA_W-1:0];
            w_c      = !w_diff[DATA_W];
            w_v      = (i_lhs[DATA_W-1] != i_rhs[DATA_W-1]) && (w_diff[DATA_W-1] != i_lhs[DATA_W-1]);
         end
         UOP_AND: o_result = i_lhs & i_rhs;
         UOP_ORR: o_result = i_lhs | i_rhs;
         UOP_EOR: o_result = i_lhs ^ i_rhs;
         UOP_MVN: o_result = ~i_rhs;
         UOP_MOV: o_result = i_rhs;
         default: o_result = '0;
      endcase
   end

   assign o_nzcv = {o_result[DATA_W-1], (o_result == '0), w_c, w_v};
endmodule

// File: rtl/execute_unit_p.sv
// Execute stage: register file, NZCV, data memory; 2-cycle LDR stalls in_ready, taken B opens a squash window.
module execute_unit_p
   import exec_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int NREGS        = 16,
   parameter int MEM_WORDS    = 64,
   parameter int FLUSH_CYCLES = 2,
   parameter int FLAGS_ON_ALU = 0
) (
   input  logic clk,
   input  logic rst,
   execute_unit_p_if.slave bus
);
   localparam int SEL_W  = $clog2(NREGS);
   localparam int ADDR_W = $clog2(MEM_WORDS);
   localparam int CNT_W  = $clog2(FLUSH_CYCLES + 1);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] r_mem  [MEM_WORDS];
   logic [DATA_W-1:0] r_rd_dat;
   logic [SEL_W-1:0]  r_ld_dst;
   logic [3:0]        r_flags;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic              r_branch_taken;
   logic [DATA_W-1:0] r_delta;
   ld_state_t         r_state;
   ld_state_t         w_state_nxt;

   logic              w_accept;
   logic              w_exec;
   logic [DATA_W-1:0] w_p0;
   logic [DATA_W-1:0] w_p1;
   logic [DATA_W-1:0] w_rhs;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_alu_res;
   logic [3:0]        w_alu_nzcv;
   logic              w_wr_reg;
   logic              w_wr_flags;
   logic              w_take;

   assign w_accept = bus.in_valid && bus.in_ready;
   // Anything accepted while the flush counter runs is dropped on the floor.
   assign w_exec   = w_accept && (r_flush_cnt == '0);

   assign w_p0   = r_regs[bus.sel_p0];
   assign w_p1   = r_regs[bus.sel_p1];
   assign w_rhs  = (bus.uop == UOP_MOV && !bus.num_to_rhs) ? w_p0 :
                   (bus.num_to_rhs ? bus.num : w_p1);
   assign w_addr = w_p1[ADDR_W-1:0] + (bus.num_to_rhs ? bus.num[ADDR_W-1:0] : '0);

   exec_alu_p #(.DATA_W(DATA_W)) u_alu (
      .i_uop    (bus.uop),
      .i_lhs    (w_p0),
      .i_rhs    (w_rhs),
      .o_result (w_alu_res),
      .o_nzcv   (w_alu_nzcv)
   );

   assign w_wr_reg   = w_exec && (bus.uop inside {UOP_ADD, UOP_SUB, UOP_AND, UOP_ORR,
                                                  UOP_EOR, UOP_MVN, UOP_MOV});
   assign w_wr_flags = w_exec && ((bus.uop == UOP_CMP) ||
                       ((FLAGS_ON_ALU != 0) && (bus.uop == UOP_ADD || bus.uop == UOP_SUB)));
   assign w_take     = w_exec && (bus.uop == UOP_B) && cond_pass(bus.branch_cond, r_flags);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_exec && bus.uop == UOP_LDR) w_state_nxt = ST_LOAD;
         ST_LOAD: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_flags        <= '0;
         r_flush_cnt    <= '0;
         r_branch_taken <= 1'b0;
         r_delta        <= '0;
         r_ld_dst       <= '0;
      end else begin
         if (w_wr_reg)            r_regs[bus.sel_in] <= w_alu_res;
         if (r_state == ST_LOAD)  r_regs[r_ld_dst]   <= r_rd_dat;
         if (w_exec && bus.uop == UOP_LDR) r_ld_dst  <= bus.sel_in;
         if (w_wr_flags)          r_flags            <= w_alu_nzcv;
         r_branch_taken <= w_take;
         r_delta        <= w_take ? bus.num : '0;
         if (w_take)                  r_flush_cnt <= CNT_W'(FLUSH_CYCLES);
         else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - CNT_W'(1);
      end
   end

   // Data memory keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (w_exec && bus.uop == UOP_STR) r_mem[w_addr] <= w_p0;
      if (w_exec && bus.uop == UOP_LDR) r_rd_dat      <= r_mem[w_addr];
   end

   assign bus.in_ready          = (r_state == ST_IDLE);
   assign bus.global_disable    = (r_flush_cnt != '0);
   assign bus.branch_taken      = r_branch_taken;
   assign bus.delta_instruction = r_delta;
   assign bus.flags             = r_flags;
endmodule

// File: tb/tb_execute_unit_p.sv
// Directed bench for execute_unit_p: default config plus a 16-bit/16-word config with ALU flags enabled.
module tb_execute_unit_p;
   import exec_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   execute_unit_p_if #(.DATA_W(32), .SEL_W(4)) bif ();
   execute_unit_p_if #(.DATA_W(16), .SEL_W(4)) bif16 ();

   execute_unit_p #(.DATA_W(32), .NREGS(16), .MEM_WORDS(64), .FLUSH_CYCLES(2), .FLAGS_ON_ALU(0))
      dut (.clk(clk), .rst(rst), .bus(bif));
   execute_unit_p #(.DATA_W(16), .NREGS(16), .MEM_WORDS(16), .FLUSH_CYCLES(2), .FLAGS_ON_ALU(1))
      dut16 (.clk(clk), .rst(rst), .bus(bif16));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      int          kind;   // 0 reg32, 1 flags32, 2 reg16, 3 flags16
      int          idx;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int kind, input int idx, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       obs = dut.r_regs[e.idx];
            1:       obs = {28'h0, bif.flags};
            2:       obs = {16'h0, dut16.r_regs[e.idx]};
            default: obs = {28'h0, bif16.flags};
         endcase
         chk(e.tag, obs, e.val);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input int which, input logic [4:0] u, input int d, input int p0,
                        input int p1, input logic imm, input logic [31:0] n,
                        input logic [3:0] c, output int stalls);
      stalls = 0;
      while (((which == 0) ? bif.in_ready : bif16.in_ready) !== 1'b1 && stalls < 20) begin
         @(negedge clk);
         stalls++;
      end
      if (stalls >= 20) chk("issue_timeout", 32'(stalls), 32'd0);
      if (which == 0) begin
         bif.uop = u; bif.sel_in = 4'(d); bif.sel_p0 = 4'(p0); bif.sel_p1 = 4'(p1);
         bif.num_to_rhs = imm; bif.num = n; bif.branch_cond = c; bif.in_valid = 1'b1;
      end else begin
         bif16.uop = u; bif16.sel_in = 4'(d); bif16.sel_p0 = 4'(p0); bif16.sel_p1 = 4'(p1);
         bif16.num_to_rhs = imm; bif16.num = n[15:0]; bif16.branch_cond = c; bif16.in_valid = 1'b1;
      end
      @(negedge clk);
      bif.in_valid = 1'b0;   bif.uop = UOP_NOP;
      bif16.in_valid = 1'b0; bif16.uop = UOP_NOP;
   endtask

   initial begin
      int st;
      bif.in_valid = 0; bif.uop = UOP_NOP; bif.num_to_rhs = 0; bif.num = 0;
      bif.sel_p0 = 0; bif.sel_p1 = 0; bif.sel_in = 0; bif.branch_cond = 0;
      bif16.in_valid = 0; bif16.uop = UOP_NOP; bif16.num_to_rhs = 0; bif16.num = 0;
      bif16.sel_p0 = 0; bif16.sel_p1 = 0; bif16.sel_in = 0; bif16.branch_cond = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_in_ready", {31'h0, bif.in_ready}, 32'd1);
      chk("rst_gdis", {31'h0, bif.global_disable}, 32'd0);
      chk("rst_btaken", {31'h0, bif.branch_taken}, 32'd0);
      chk("rst_delta", bif.delta_instruction, 32'd0);
      push("rst_flags", 1, 0, 32'h0);
      push("rst_r4", 0, 4, 32'h0);
      drain();

      issue(0, UOP_MOV, 1, 0, 0, 1, 32'hCAFE, 0, st);
      issue(0, UOP_MOV, 2, 0, 0, 1, 32'hDEAD, 0, st);
      issue(0, UOP_ADD, 4, 1, 2, 0, 32'h0, 0, st);
      push("add_r4", 0, 4, 32'h0001A9AB);
      push("add_flags_untouched", 1, 0, 32'h0);
      drain();

      issue(0, UOP_MOV, 6, 0, 0, 1, 32'd1, 0, st);
      issue(0, UOP_MOV, 7, 0, 0, 1, 32'd1, 0, st);
      issue(0, UOP_CMP, 0, 6, 7, 0, 32'h0, 0, st);
      push("cmp_eq_flags", 1, 0, 32'b0110);
      drain();
      issue(0, UOP_CMP, 0, 6, 0, 1, 32'd2, 0, st);
      push("cmp_lt_flags", 1, 0, 32'b1000);
      drain();

      issue(0, UOP_STR, 0, 1, 6, 1, 32'd28, 0, st);
      issue(0, UOP_LDR, 8, 0, 6, 1, 32'd28, 0, st);
      chk("ldr_in_ready_low", {31'h0, bif.in_ready}, 32'd0);
      issue(0, UOP_ADD, 9, 8, 8, 0, 32'h0, 0, st);
      chk("ldr_stall_cycles", 32'(st), 32'd1);
      push("ldr_r8", 0, 8, 32'hCAFE);
      push("dep_add_r9", 0, 9, 32'h000195FC);
      drain();

      issue(0, UOP_CMP, 0, 6, 7, 0, 32'h0, 0, st);
      issue(0, UOP_B, 0, 0, 0, 1, 32'hFFFFFFFD, COND_EQ, st);
      chk("beq_taken", {31'h0, bif.branch_taken}, 32'd1);
      chk("beq_delta", bif.delta_instruction, 32'hFFFFFFFD);
      chk("beq_gdis_c1", {31'h0, bif.global_disable}, 32'd1);
      issue(0, UOP_MOV, 10, 0, 0, 1, 32'd5, 0, st);
      chk("beq_pulse_end", {31'h0, bif.branch_taken}, 32'd0);
      chk("beq_delta_clear", bif.delta_instruction, 32'd0);
      chk("beq_gdis_c2", {31'h0, bif.global_disable}, 32'd1);
      @(negedge clk);
      chk("beq_gdis_end", {31'h0, bif.global_disable}, 32'd0);
      push("squashed_mov_r10", 0, 10, 32'h0);
      push("flags_after_window", 1, 0, 32'b0110);
      drain();

      issue(0, UOP_B, 0, 0, 0, 1, 32'd4, COND_NV, st);
      chk("bnv_not_taken", {30'h0, bif.branch_taken, bif.global_disable}, 32'd0);
      issue(0, UOP_B, 0, 0, 0, 1, 32'd4, COND_NE, st);
      chk("bne_not_taken", {30'h0, bif.branch_taken, bif.global_disable}, 32'd0);
      chk("bne_delta_zero", bif.delta_instruction, 32'd0);
      issue(0, UOP_B, 0, 0, 0, 1, 32'd8, COND_AL, st);
      chk("bal_taken", {31'h0, bif.branch_taken}, 32'd1);
      chk("bal_delta", bif.delta_instruction, 32'd8);
      issue(0, UOP_B, 0, 0, 0, 1, 32'd12, COND_AL, st);
      chk("squashed_b_no_pulse", {31'h0, bif.branch_taken}, 32'd0);
      chk("squashed_b_gdis", {31'h0, bif.global_disable}, 32'd1);
      @(negedge clk);
      chk("squashed_b_no_restart", {31'h0, bif.global_disable}, 32'd0);

      issue(0, UOP_LDR, 11, 0, 6, 1, 32'd28, 0, st);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_load_in_ready", {31'h0, bif.in_ready}, 32'd1);
      push("rst_load_r11", 0, 11, 32'h0);
      push("rst_load_flags", 1, 0, 32'h0);
      push("rst_load_r1", 0, 1, 32'h0);
      @(negedge clk);
      drain();

      issue(1, UOP_MOV, 1, 0, 0, 1, 32'h1234, 0, st);
      issue(1, UOP_STR, 0, 1, 0, 1, 32'd20, 0, st);
      issue(1, UOP_LDR, 2, 0, 0, 1, 32'd4, 0, st);
      @(negedge clk);
      push("w16_wrap_r2", 2, 2, 32'h1234);
      drain();
      issue(1, UOP_ADD, 3, 1, 0, 1, 32'hEDCC, 0, st);
      push("w16_add_r3", 2, 3, 32'h0);
      push("w16_add_flags", 3, 0, 32'b0110);
      drain();
      issue(1, UOP_SUB, 4, 0, 0, 1, 32'h8000, 0, st);
      push("w16_sub_r4", 2, 4, 32'h8000);
      push("w16_sub_flags", 3, 0, 32'b1001);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
